// File: rtl/ram_copy_engine_if.sv
// Command and RAM-port bundle for ram_copy_engine.
// The slave modport is the engine's view; master is the controller plus RAM side.
interface ram_copy_engine_if #(
   parameter int N = 6,
   parameter int M = 32
) ();
   logic         start;
   logic         mode;
   logic [N-1:0] src_addr;
   logic [N-1:0] dst_addr;
   logic [N:0]   length;
   logic [M-1:0] fill_value;
   logic         busy;
   logic         done;
   logic [M-1:0] checksum;
   logic         mem_we;
   logic [N-1:0] mem_addr;
   logic [M-1:0] mem_wdata;
   logic [M-1:0] mem_rdata;

   modport master (
      output start, mode, src_addr, dst_addr, length, fill_value, mem_rdata,
      input  busy, done, checksum, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  start, mode, src_addr, dst_addr, length, fill_value, mem_rdata,
      output busy, done, checksum, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/ram_copy_engine.sv
// Block copy / block fill sequencer driving a single-port RAM with a combinational
// read port; accumulates a modulo-2**M checksum of every word written.
module ram_copy_engine #(
   parameter int N = 6,
   parameter int M = 32
) (
   input logic               clk,
   input logic               rst,
   ram_copy_engine_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e       state_q, state_d;
   logic         mode_q, mode_d;
   logic [N-1:0] src_q, src_d;
   logic [N-1:0] dst_q, dst_d;
   logic [N:0]   len_q, len_d;
   logic [N:0]   count_q, count_d;
   logic [M-1:0] fill_q, fill_d;
   logic [M-1:0] data_q, data_d;
   logic [M-1:0] sum_q, sum_d;

   logic [N:0]   count_inc;
   logic         we;
   logic [N-1:0] addr;
   logic [M-1:0] wdata;

   assign count_inc = count_q + {{N{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         count_q <= '0;
         fill_q  <= '0;
         data_q  <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         count_q <= count_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      count_d = count_q;
      fill_d  = fill_q;
      data_d  = data_q;
      sum_d   = sum_q;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               mode_d  = bus.mode;
               src_d   = bus.src_addr;
               dst_d   = bus.dst_addr;
               len_d   = bus.length;
               fill_d  = bus.fill_value;
               count_d = '0;
               sum_d   = '0;
               if (bus.length == '0)
                  state_d = DONE;
               else if (bus.mode)
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ: begin
            addr    = src_q + count_q[N-1:0];
            data_d  = bus.mem_rdata;
            state_d = WRITE;
         end
         WRITE: begin
            we      = 1'b1;
            addr    = dst_q + count_q[N-1:0];
            wdata   = mode_q ? fill_q : data_q;
            sum_d   = sum_q + wdata;
            count_d = count_inc;
            // count_inc is N+1 bits so a full 2**N-word command terminates correctly
            if (count_inc == len_q)
               state_d = DONE;
            else if (mode_q)
               state_d = WRITE;
            else
               state_d = READ;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q == READ) || (state_q == WRITE);
   assign bus.done      = (state_q == DONE);
   assign bus.checksum  = sum_q;
   assign bus.mem_we    = we;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = wdata;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine: behavioural RAM plus an array-based
// reference model of copy/fill results, checksum and latency.
module tb_ram_copy_engine;
   localparam int N     = 6;
   localparam int M     = 32;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_copy_engine_if #(.N(N), .M(M)) bus ();
   ram_copy_engine #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [M-1:0] mem [DEPTH];
   logic [M-1:0] ref_mem [DEPTH];
   assign bus.mem_rdata = mem[bus.mem_addr];

   int checks   = 0;
   int errors   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int wr_q[$];

   // RAM write port and activity monitor
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) begin
         mem[bus.mem_addr] = bus.mem_wdata;
         wr_q.push_back(int'(bus.mem_addr));
         wr_cnt++;
      end
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic clear_mon();
      wr_q.delete();
      wr_cnt = 0;
   endtask

   task automatic preload_random();
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
   endtask

   task automatic poke(input int a, input logic [M-1:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   // Reference: words are moved one by one in ascending order, addresses modulo DEPTH
   function automatic logic [M-1:0] model_cmd(input logic md, input int src, input int dst,
                                               input int len, input logic [M-1:0] fv);
      logic [M-1:0] sum;
      logic [M-1:0] v;
      sum = '0;
      for (int i = 0; i < len; i++) begin
         v = md ? fv : ref_mem[(src + i) % DEPTH];
         ref_mem[(dst + i) % DEPTH] = v;
         sum += v;
      end
      return sum;
   endfunction

   function automatic int exp_latency(input logic md, input int len);
      if (len == 0) return 1;
      return md ? len + 1 : 2 * len + 1;
   endfunction

   function automatic int mem_diffs();
      int d;
      d = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) d++;
      return d;
   endfunction

   function automatic int addr_seq_bad(input int dst, input int len);
      if (wr_q.size() != len) return 1;
      for (int i = 0; i < len; i++) if (wr_q[i] != (dst + i) % DEPTH) return 1;
      return 0;
   endfunction

   task automatic issue_cmd(input logic md, input int src, input int dst, input int len,
                            input logic [M-1:0] fv);
      @(negedge clk);
      bus.mode       = md;
      bus.src_addr   = N'(src);
      bus.dst_addr   = N'(dst);
      bus.length     = (N+1)'(len);
      bus.fill_value = fv;
      bus.start      = 1'b1;
      @(posedge clk);
      #1 bus.start   = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit to);
      lat = 0;
      to  = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = i;
            to  = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.checksum !== 32'h0) begin errors++; $display("FAIL reset_checksum: got %h expected 0", bus.checksum); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.mem_we); end
      checks++; if (bus.mem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill();
      int lat; bit to; int dc;
      preload_random();
      void'(model_cmd(1'b1, 0, 8, 4, 32'hA5A5A5A5));
      clear_mon();
      dc = done_cnt;
      issue_cmd(1'b1, 0, 8, 4, 32'hA5A5A5A5);
      wait_done(lat, to);
      checks++; if (to) begin errors++; $display("FAIL fill_timeout: got no done expected done"); end
      checks++; if (lat != 5) begin errors++; $display("FAIL fill_latency: got %0d expected 5", lat); end
      checks++; if (addr_seq_bad(8, 4) != 0) begin errors++; $display("FAIL fill_addrs: got %0d writes expected 8..11", wr_q.size()); end
      checks++; if (bus.checksum !== 32'h96969694) begin errors++; $display("FAIL fill_checksum: got %h expected 96969694", bus.checksum); end
      checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL fill_mem: got %0d bad words expected 0", mem_diffs()); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL fill_done_width: got %b expected 0", bus.done); end
      repeat (3) @(negedge clk);
      checks++; if (done_cnt - dc != 1) begin errors++; $display("FAIL fill_done_count: got %0d expected 1", done_cnt - dc); end
      checks++; if (bus.checksum !== 32'h96969694) begin errors++; $display("FAIL fill_checksum_hold: got %h expected 96969694", bus.checksum); end
   endtask

   task automatic test_copy();
      int lat; bit to;
      preload_random();
      poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3);
      void'(model_cmd(1'b0, 0, 20, 3, '0));
      clear_mon();
      issue_cmd(1'b0, 0, 20, 3, 32'hFFFF_FFFF);
      wait_done(lat, to);
      checks++; if (to || lat != 7) begin errors++; $display("FAIL copy_latency: got %0d (timeout %0d) expected 7", lat, to); end
      checks++; if (addr_seq_bad(20, 3) != 0) begin errors++; $display("FAIL copy_addrs: got %0d writes expected 20..22", wr_q.size()); end
      checks++; if (mem[20] !== 32'd1 || mem[21] !== 32'd2 || mem[22] !== 32'd3) begin
         errors++; $display("FAIL copy_data: got %0d %0d %0d expected 1 2 3", mem[20], mem[21], mem[22]); end
      checks++; if (bus.checksum !== 32'd6) begin errors++; $display("FAIL copy_checksum: got %0d expected 6", bus.checksum); end
      checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL copy_mem: got %0d bad words expected 0", mem_diffs()); end
   endtask

   task automatic test_wrap();
      int lat; bit to; logic [M-1:0] fv; logic [M-1:0] e;
      fv = $urandom;
      preload_random();
      void'(model_cmd(1'b1, 0, 62, 4, fv));
      clear_mon();
      issue_cmd(1'b1, 0, 62, 4, fv);
      wait_done(lat, to);
      checks++; if (to || lat != 5) begin errors++; $display("FAIL wrap_latency: got %0d expected 5", lat); end
      checks++; if (wr_q.size() != 4 || wr_q[0] != 62 || wr_q[1] != 63 || wr_q[2] != 0 || wr_q[3] != 1) begin
         errors++; $display("FAIL wrap_addrs: got %0d writes expected 62 63 0 1", wr_q.size()); end
      checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL wrap_mem: got %0d bad words expected 0", mem_diffs()); end
      // full-memory fill
      fv = $urandom;
      e  = fv << 6;
      preload_random();
      clear_mon();
      issue_cmd(1'b1, 0, 37, 64, fv);
      wait_done(lat, to);
      checks++; if (to || lat != 65) begin errors++; $display("FAIL full_latency: got %0d expected 65", lat); end
      checks++; if (wr_cnt != 64) begin errors++; $display("FAIL full_writes: got %0d expected 64", wr_cnt); end
      checks++; if (addr_seq_bad(37, 64) != 0) begin errors++; $display("FAIL full_addrs: got %0d writes expected each address once", wr_q.size()); end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = fv;
      checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL full_mem: got %0d bad words expected 0", mem_diffs()); end
      checks++; if (bus.checksum !== e) begin errors++; $display("FAIL full_checksum: got %h expected %h", bus.checksum, e); end
   endtask

   task automatic test_overlap();
      int lat; bit to;
      preload_random();
      poke(0, 32'd9); poke(1, 32'd1); poke(2, 32'd2); poke(3, 32'd3);
      clear_mon();
      issue_cmd(1'b0, 0, 1, 3, '0);
      wait_done(lat, to);
      checks++; if (to || lat != 7) begin errors++; $display("FAIL overlap_latency: got %0d expected 7", lat); end
      checks++; if (mem[1] !== 32'd9 || mem[2] !== 32'd9 || mem[3] !== 32'd9) begin
         errors++; $display("FAIL overlap_data: got %0d %0d %0d expected 9 9 9", mem[1], mem[2], mem[3]); end
      checks++; if (bus.checksum !== 32'd27) begin errors++; $display("FAIL overlap_checksum: got %0d expected 27", bus.checksum); end
   endtask

   task automatic test_zero_len();
      int lat; bit to;
      clear_mon();
      issue_cmd(1'b1, 5, 9, 0, 32'h1234_5678);
      wait_done(lat, to);
      checks++; if (to || lat != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
      checks++; if (wr_cnt != 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt); end
      checks++; if (bus.checksum !== 32'h0) begin errors++; $display("FAIL zero_checksum: got %h expected 0", bus.checksum); end
   endtask

   task automatic test_ignored_start();
      int n; int dc; bit seen;
      logic [M-1:0] fv;
      fv = $urandom;
      preload_random();
      clear_mon();
      dc = done_cnt;
      seen = 1'b0;
      issue_cmd(1'b1, 0, 30, 4, fv);
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            // a start presented during DONE must also be dropped
            bus.mode = 1'b1; bus.dst_addr = 6'd0; bus.length = 7'd10; bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            seen = 1'b1;
            break;
         end
         if (n == 2) begin
            bus.mode = 1'b0; bus.src_addr = 6'd0; bus.dst_addr = 6'd0; bus.length = 7'd10; bus.start = 1'b1;
         end
         if (n == 3) bus.start = 1'b0;
      end
      repeat (6) @(negedge clk);
      checks++; if (!seen) begin errors++; $display("FAIL ignored_timeout: got no done expected done"); end
      checks++; if (wr_cnt != 4) begin errors++; $display("FAIL ignored_writes: got %0d expected 4", wr_cnt); end
      checks++; if (addr_seq_bad(30, 4) != 0) begin errors++; $display("FAIL ignored_addrs: got %0d writes expected 30..33", wr_q.size()); end
      checks++; if (done_cnt - dc != 1) begin errors++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt - dc); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_reset_mid_copy();
      int lat; bit to; int dc; bit hit; logic [M-1:0] s;
      preload_random();
      void'(model_cmd(1'b0, 10, 40, 2, '0));
      clear_mon();
      dc  = done_cnt;
      hit = 1'b0;
      issue_cmd(1'b0, 10, 40, 5, '0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_cnt == 2) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) begin errors++; $display("FAIL rstmid_progress: got %0d writes expected 2", wr_cnt); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b expected 0", bus.mem_we); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.checksum !== 32'h0) begin errors++; $display("FAIL rstmid_checksum: got %h expected 0", bus.checksum); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (wr_cnt != 2) begin errors++; $display("FAIL rstmid_writes: got %0d expected 2", wr_cnt); end
      checks++; if (done_cnt != dc) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt - dc); end
      checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL rstmid_mem: got %0d bad words expected 0", mem_diffs()); end
      s = model_cmd(1'b0, 0, 50, 3, '0);
      clear_mon();
      issue_cmd(1'b0, 0, 50, 3, '0);
      wait_done(lat, to);
      checks++; if (to || lat != 7) begin errors++; $display("FAIL rstmid_after_latency: got %0d expected 7", lat); end
      checks++; if (bus.checksum !== s) begin errors++; $display("FAIL rstmid_after_checksum: got %h expected %h", bus.checksum, s); end
      checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL rstmid_after_mem: got %0d bad words expected 0", mem_diffs()); end
   endtask

   task automatic test_random();
      int lat; bit to; logic md; int src; int dst; int len; logic [M-1:0] fv; logic [M-1:0] s;
      for (int k = 0; k < 20; k++) begin
         md  = 1'($urandom_range(0, 1));
         src = $urandom_range(0, DEPTH - 1);
         dst = $urandom_range(0, DEPTH - 1);
         len = (k % 5 == 0) ? DEPTH : $urandom_range(0, DEPTH - 1);
         fv  = $urandom;
         preload_random();
         s = model_cmd(md, src, dst, len, fv);
         clear_mon();
         issue_cmd(md, src, dst, len, fv);
         wait_done(lat, to);
         checks++; if (to || lat != exp_latency(md, len)) begin
            errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, exp_latency(md, len)); end
         checks++; if (addr_seq_bad(dst, len) != 0) begin
            errors++; $display("FAIL rand_addrs[%0d]: got %0d writes expected %0d from %0d", k, wr_q.size(), len, dst); end
         checks++; if (mem_diffs() != 0) begin
            errors++; $display("FAIL rand_mem[%0d]: got %0d bad words expected 0", k, mem_diffs()); end
         checks++; if (bus.checksum !== s) begin
            errors++; $display("FAIL rand_checksum[%0d]: got %h expected %h", k, bus.checksum, s); end
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.mode       = 1'b0;
      bus.src_addr   = '0;
      bus.dst_addr   = '0;
      bus.length     = '0;
      bus.fill_value = '0;
      for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      test_reset();
      test_fill();
      test_copy();
      test_wrap();
      test_overlap();
      test_zero_len();
      test_ignored_start();
      test_reset_mid_copy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
